// File: rtl/cmd_dispatch_if.sv
// cmd_dispatch_if: command, register-file and transmitter signals of cmd_dispatch.
interface cmd_dispatch_if;
  logic        cmd_rdy;
  logic [23:0] cmd;
  logic [15:0] rd_data;
  logic        tx_done;
  logic        wr_en;
  logic        rd_en;
  logic [5:0]  addr;
  logic [15:0] wr_data;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        busy;
  logic        err;
  logic        ovr;
  modport master (
    output cmd_rdy, cmd, rd_data, tx_done,
    input  wr_en, rd_en, addr, wr_data, trmt, tx_data, busy, err, ovr
  );
  modport slave (
    input  cmd_rdy, cmd, rd_data, tx_done,
    output wr_en, rd_en, addr, wr_data, trmt, tx_data, busy, err, ovr
  );
endinterface

// File: rtl/cmd_dispatch.sv
// cmd_dispatch: decodes 24-bit commands, strobes the register file and returns ACK/NAK or read bytes.
// Optional transmit watchdog enabled by defining CMD_DISPATCH_TIMEOUT_EN.
module cmd_dispatch #(
  parameter logic [7:0] ACK     = 8'hA5,
  parameter logic [7:0] NAK     = 8'hEE,
  parameter int         TIMEOUT = 1024
) (
  input logic           clk,
  input logic           rst_n,
  cmd_dispatch_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD_CAP, SEND, WAIT} state_t;
  state_t     state_q, state_d;
  logic [7:0] tx_data_q, tx_data_d, lo_q, lo_d;
  logic       two_q, two_d, err_q, err_d, ovr_q, ovr_d, trmt_q, busy_q;
  logic [1:0] op;
  logic       idle_cmd, expire;
  assign op       = bus.cmd[23:22];
  assign idle_cmd = bus.cmd_rdy && state_q == IDLE;
`ifdef CMD_DISPATCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_d;
  assign expire = state_q == WAIT && !bus.tx_done && cnt_q == CW'(TIMEOUT - 1);
  assign cnt_d  = state_q == SEND ? '0 : state_q == WAIT ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign expire = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    lo_d      = lo_q;
    two_d     = two_q;
    err_d     = err_q;
    ovr_d     = ovr_q | (bus.cmd_rdy && state_q != IDLE);
    case (state_q)
      IDLE: if (bus.cmd_rdy) begin
        err_d     = op == 2'b11;
        two_d     = 1'b0;
        tx_data_d = op == 2'b10 ? tx_data_q : op == 2'b11 ? NAK : ACK;
        state_d   = op == 2'b10 ? RD_CAP : SEND;
      end
      RD_CAP: begin
        lo_d      = bus.rd_data[7:0];
        tx_data_d = bus.rd_data[15:8];
        two_d     = 1'b1;
        state_d   = SEND;
      end
      SEND: state_d = WAIT;
      WAIT: if (bus.tx_done) begin
        tx_data_d = two_q ? lo_q : tx_data_q;
        two_d     = 1'b0;
        state_d   = two_q ? SEND : IDLE;
      end else if (expire) begin
        err_d   = 1'b1;
        two_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
      lo_q      <= '0;
      two_q     <= 1'b0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
      trmt_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      lo_q      <= lo_d;
      two_q     <= two_d;
      err_q     <= err_d;
      ovr_q     <= ovr_d;
      trmt_q    <= state_d == SEND;
      busy_q    <= state_d != IDLE;
    end
  assign bus.wr_en   = idle_cmd && op == 2'b01;
  assign bus.rd_en   = idle_cmd && op == 2'b10;
  assign bus.addr    = bus.cmd[21:16];
  assign bus.wr_data = bus.cmd[15:0];
  assign bus.trmt    = trmt_q;
  assign bus.tx_data = tx_data_q;
  assign bus.busy    = busy_q;
  assign bus.err     = err_q;
  assign bus.ovr     = ovr_q;
endmodule
